data_memory_ctrl: RTL and testbench



---
 rtl/data_memory_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-addressed data memory with a valid/ready request
// port, one-cycle response pulse, post-reset clear, byte-enabled writes,
// configurable wait states and out-of-range flagging.
module data_memory_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]       WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0
                                                              : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;

  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  // Access operands: with no wait states the access happens on the accept
  // edge itself, so the live request inputs are used instead of the capture.
  logic              enter_resp;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_in_range;
  logic [DATA_W-1:0] acc_cur;
  logic [DATA_W-1:0] acc_merged;

  // Next-state, capture, clear sequencing and memory access decode.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_widx    = '0;
    mem_wdata   = '0;
    enter_resp  = 1'b0;

    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_idx      = acc_addr[IDX_W-1:0];
    acc_in_range = ({1'b0, acc_addr} < DEPTH_EXT);
    acc_cur      = mem_q[acc_idx];
    acc_merged   = acc_cur;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (acc_be[i]) begin
        acc_merged[8*i +: 8] = acc_wdata[8*i +: 8];
      end
    end

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_widx  = init_cnt_q;
        mem_wdata = '0;
        if (init_cnt_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (enter_resp) begin
      if (!acc_in_range) begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end else if (acc_write) begin
        rsp_rdata_d = acc_merged;
        rsp_err_d   = 1'b0;
        mem_we      = 1'b1;
        mem_widx    = acc_idx;
        mem_wdata   = acc_merged;
      end else begin
        rsp_rdata_d = acc_cur;
        rsp_err_d   = 1'b0;
      end
    end

    // Synchronous reset overrides everything, including any pending write.
    if (reset) begin
      state_d     = ST_INIT;
      init_cnt_d  = '0;
      wait_cnt_d  = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      mem_we      = 1'b0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    init_cnt_q  <= init_cnt_d;
    wait_cnt_q  <= wait_cnt_d;
    wr_q        <= wr_d;
    addr_q      <= addr_d;
    wdata_q     <= wdata_d;
    be_q        <= be_d;
    rsp_rdata_q <= rsp_rdata_d;
    rsp_err_q   <= rsp_err_d;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign init_busy = (state_q == ST_INIT);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: three instances (1, 3 and 0 wait states) driven with
// directed and random requests, checked against a word-array reference model.
module tb_data_memory_ctrl;

  localparam int NI    = 3;
  localparam int DEPTH = 64;

  logic             clk;
  logic [NI-1:0]    reset;
  logic [NI-1:0]    req_valid;
  logic [NI-1:0]    req_ready;
  logic [NI-1:0]    req_write;
  logic [15:0]      req_addr  [NI];
  logic [31:0]      req_wdata [NI];
  logic [3:0]       req_be    [NI];
  logic [NI-1:0]    rsp_valid;
  logic [31:0]      rsp_rdata [NI];
  logic [NI-1:0]    rsp_err;
  logic [NI-1:0]    init_busy;

  int               wait_of [NI];
  logic [31:0]      mdl [NI][DEPTH];

  int               n_cmp;
  int               n_bad;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_memory_ctrl #(
      .DATA_W     (32),
      .ADDR_W     (16),
      .DEPTH      (DEPTH),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .init_busy(init_busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, check reset outputs, then time the clear sequence.
  task automatic do_init(input int d);
    int busy;
    reset[d] = 1'b1;
    req_valid[d] = 1'b0;
    tick();
    check_eq("rst_rsp_valid", rsp_valid[d], 0);
    tick();
    check_eq("rst_ready", req_ready[d], 0);
    check_eq("rst_rsp_valid", rsp_valid[d], 0);
    check_eq("rst_rdata", rsp_rdata[d], 0);
    check_eq("rst_err", rsp_err[d], 0);
    check_eq("rst_busy", init_busy[d], 1);
    reset[d] = 1'b0;
    for (int a = 0; a < DEPTH; a++) mdl[d][a] = '0;
    busy = 0;
    while (init_busy[d] === 1'b1 && busy < 200) begin
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0) check_eq("init_quiet", {req_ready[d], rsp_valid[d]}, 0);
      busy++;
      tick();
    end
    check_eq("init_cycles", busy, DEPTH);
    check_eq("ready_after_init", req_ready[d], 1);
  endtask

  // One request through the port, checked for latency, data, error and the
  // single-cycle response pulse against the model.
  task automatic do_txn(input int d, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    int n;
    int lat;
    logic [31:0] exp_data;
    logic        exp_err;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_be[d]    = be;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq("ready_wait", (n < 100), 1);
    tick();
    req_valid[d] = 1'b0;
    req_write[d] = $urandom_range(0, 1);
    req_addr[d]  = 16'($urandom);
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);

    if (addr >= DEPTH) begin
      exp_err  = 1'b1;
      exp_data = '0;
    end else begin
      exp_err  = 1'b0;
      exp_data = mdl[d][addr];
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) exp_data[8*b +: 8] = wd[8*b +: 8];
        end
        mdl[d][addr] = exp_data;
      end
    end

    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      check_eq("ready_low_busy", req_ready[d], 0);
      tick();
      lat++;
    end
    check_eq("latency", lat, wait_of[d]);
    check_eq("rsp_rdata", rsp_rdata[d], exp_data);
    check_eq("rsp_err", rsp_err[d], exp_err);
    tick();
    check_eq("pulse_end", rsp_valid[d], 0);
    check_eq("ready_again", req_ready[d], 1);
  endtask

  initial begin
    int prev_ready;
    int prev_rsp;
    int n_rsp;
    n_cmp = 0;
    n_bad = 0;
    wait_of[0] = 1;
    wait_of[1] = 3;
    wait_of[2] = 0;
    reset     = '1;
    req_valid = '0;
    req_write = '0;
    for (int d = 0; d < NI; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
    end
    repeat (2) tick();

    for (int d = 0; d < NI; d++) do_init(d);

    // Directed sequence, one wait state.
    do_txn(0, 0, 16'd10, 32'h0, 4'h0);
    do_txn(0, 1, 16'd3, 32'hDEADBEEF, 4'hF);
    do_txn(0, 0, 16'd3, 32'h0, 4'h0);
    do_txn(0, 1, 16'd3, 32'h00005500, 4'b0010);
    check_eq("be_model", mdl[0][3], 32'hDEAD55EF);
    do_txn(0, 0, 16'd3, 32'h0, 4'h0);
    do_txn(0, 1, 16'd3, 32'h11223344, 4'h0);
    do_txn(0, 1, 16'd64, 32'h12345678, 4'hF);
    do_txn(0, 0, 16'd0, 32'h0, 4'h0);
    do_txn(0, 0, 16'd65535, 32'h0, 4'h0);

    // Reset during WAIT on the three-wait-state instance drops the write.
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 16'd5;
    req_wdata[1] = 32'hCAFEF00D;
    req_be[1]    = 4'hF;
    tick();
    req_valid[1] = 1'b0;
    check_eq("accepted_wait", req_ready[1], 0);
    tick();
    check_eq("mid_wait_rsp", rsp_valid[1], 0);
    do_init(1);
    do_txn(1, 0, 16'd5, 32'h0, 4'h0);

    // Zero wait states, back-to-back alternating write/read of addr 7.
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 16'd7;
    req_wdata[2] = 32'h00000024;
    req_be[2]    = 4'hF;
    prev_ready = int'(req_ready[2]);
    prev_rsp   = int'(rsp_valid[2]);
    n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (prev_ready == 1) req_write[2] = ~req_write[2];
      if (rsp_valid[2] === 1'b1) begin
        n_rsp++;
        check_eq("b2b_rdata", rsp_rdata[2], 32'h00000024);
        if (prev_rsp == 1) check_eq("b2b_consecutive", 1, 0);
      end
      prev_ready = int'(req_ready[2]);
      prev_rsp   = int'(rsp_valid[2]);
    end
    req_valid[2] = 1'b0;
    check_eq("b2b_count", n_rsp, 6);
    mdl[2][7] = 32'h00000024;
    tick();
    do_txn(2, 0, 16'd7, 32'h0, 4'h0);

    // Random traffic on every instance.
    for (int d = 0; d < NI; d++) begin
      for (int t = 0; t < 25; t++) begin
        do_txn(d, $urandom_range(0, 1), 16'($urandom_range(0, 70)),
               $urandom, 4'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
